// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one AND/OR/ADD/SLT slice stepped LSB to MSB, one bit per clock.
// Optional zero flag port and logic are built only when ALU_SERIAL_ZERO_EN is defined.
module alu_serial_seq #(
  parameter int W     = 8,
  parameter int CNT_W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic         binvert,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         overflow
`ifdef ALU_SERIAL_ZERO_EN
  ,
  output logic         zero
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_ADD = 2'd2,
    OP_SLT = 2'd3
  } op_e;

  state_e             state, state_next;
  op_e                op_q;
  logic               binv_q;
  logic [W-1:0]       a_q, b_q;
  logic [CNT_W-1:0]   idx;
  logic               carry;
  logic               ovf_q, set_q;

  logic               accept;
  logic               last;
  logic               a_bit, b_bit, b2, sum, carry_next, res_bit;
  logic               ovf_bit, set_bit;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (idx == CNT_W'(W - 1));
  assign busy   = (state == RUN) || (state == FIN);
  assign done   = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is registered with non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned and infers a latch.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = FIN;
      FIN:     state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One-bit ALU slice on the current bit position.
  always_comb begin
    a_bit      = a_q[idx];
    b_bit      = b_q[idx];
    b2         = binv_q ? ~b_bit : b_bit;
    sum        = a_bit ^ b2 ^ carry;
    carry_next = (a_bit & b2) | (a_bit & carry) | (b2 & carry);
    res_bit    = 1'b0;
    case (op_q)
      OP_AND:  res_bit = a_bit & b_bit;
      OP_OR:   res_bit = a_bit | b_bit;
      OP_ADD:  res_bit = sum;
      default: res_bit = 1'b0;
    endcase
    ovf_bit = (op_q == OP_ADD) && (a_bit == b2) && (sum != a_bit);
    set_bit = (a_bit != b2) ? sum : a_bit;
  end

  // NOTE: operand registers carry no reset; they are always loaded on accept before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= a;
      b_q    <= b;
      op_q   <= op_e'(op);
      binv_q <= binvert;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry    <= 1'b0;
      idx      <= '0;
      result   <= '0;
      overflow <= 1'b0;
      ovf_q    <= 1'b0;
      set_q    <= 1'b0;
    end else if (accept) begin
      carry <= binvert;
      idx   <= '0;
    end else if (state == RUN) begin
      carry       <= carry_next;
      result[idx] <= res_bit;
      if (last) begin
        idx   <= '0;
        ovf_q <= ovf_bit;
        set_q <= set_bit;
      end else begin
        idx <= idx + 1'b1;
      end
    end else if (state == FIN) begin
      if (op_q == OP_SLT) result[0] <= set_q;
      overflow <= ovf_q;
    end
  end

`ifdef ALU_SERIAL_ZERO_EN
  // For SLT every bit above bit 0 was written as 0, so only the set bit decides.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero <= 1'b0;
    end else if (state == FIN) begin
      if (op_q == OP_SLT) zero <= ~set_q;
      else                zero <= (result == '0);
    end
  end
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq (W=8); zero flag checked when ALU_SERIAL_ZERO_EN is defined.
module tb_alu_serial_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic         binvert;
  logic [W-1:0] a, b;
  logic         busy, done, overflow;
  logic [W-1:0] result;
`ifdef ALU_SERIAL_ZERO_EN
  logic         zero;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_ADD = 2'd2;
  localparam logic [1:0] OP_SLT = 2'd3;

  alu_serial_seq #(.W(W), .CNT_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .binvert  (binvert),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
`ifdef ALU_SERIAL_ZERO_EN
    ,
    .zero     (zero)
`endif
  );

  always #5 clk = ~clk;

  // Drive one start for a single edge; returns 1 ns after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic bi, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; binvert = bi; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen; returns 40 on timeout.
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (done) break;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 2'd0; binvert = 1'b0; a = '0; b = '0;
    #12;
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 8'h00)  begin errors++; $display("FAIL reset_result got=%h exp=00", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
`ifdef ALU_SERIAL_ZERO_EN
    checks++; if (zero !== 1'b0)     begin errors++; $display("FAIL reset_zero got=%b exp=0", zero); end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_add;
    int n;
    issue(OP_ADD, 1'b0, 8'h7F, 8'h01);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy got=%b exp=1", busy); end
    wait_done(n);
    checks++; if (n != W + 1)         begin errors++; $display("FAIL add_latency got=%0d exp=%0d", n, W + 1); end
    checks++; if (result !== 8'h80)   begin errors++; $display("FAIL add_result got=%h exp=80", result); end
    checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL add_overflow got=%b exp=1", overflow); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL add_busy_done got=%b exp=0", busy); end
`ifdef ALU_SERIAL_ZERO_EN
    checks++; if (zero !== 1'b0)      begin errors++; $display("FAIL add_zero got=%b exp=0", zero); end
`endif
    @(posedge clk); #1;
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL add_done_pulse got=%b exp=0", done); end
    checks++; if (result !== 8'h80)   begin errors++; $display("FAIL add_result_hold got=%h exp=80", result); end
    checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL add_overflow_hold got=%b exp=1", overflow); end
  endtask

  task automatic test_sub;
    int n;
    issue(OP_ADD, 1'b1, 8'h05, 8'h07);
    wait_done(n);
    checks++; if (n != W + 1)        begin errors++; $display("FAIL sub_latency got=%0d exp=%0d", n, W + 1); end
    checks++; if (result !== 8'hFE)  begin errors++; $display("FAIL sub_result got=%h exp=FE", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sub_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_slt;
    int n;
    issue(OP_SLT, 1'b1, 8'h80, 8'h01);
    wait_done(n);
    checks++; if (result !== 8'h01)  begin errors++; $display("FAIL slt_neg_result got=%h exp=01", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL slt_neg_overflow got=%b exp=0", overflow); end
    issue(OP_SLT, 1'b1, 8'h7F, 8'h80);
    wait_done(n);
    checks++; if (result !== 8'h00)  begin errors++; $display("FAIL slt_pos_result got=%h exp=00", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL slt_pos_overflow got=%b exp=0", overflow); end
`ifdef ALU_SERIAL_ZERO_EN
    checks++; if (zero !== 1'b1)     begin errors++; $display("FAIL slt_pos_zero got=%b exp=1", zero); end
`endif
  endtask

  task automatic test_and_or;
    int n;
    issue(OP_AND, 1'b1, 8'hC3, 8'h5A);
    wait_done(n);
    checks++; if (result !== 8'h42)  begin errors++; $display("FAIL and_result got=%h exp=42", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL and_overflow got=%b exp=0", overflow); end
    issue(OP_OR, 1'b1, 8'hC3, 8'h5A);
    wait_done(n);
    checks++; if (result !== 8'hDB)  begin errors++; $display("FAIL or_result got=%h exp=DB", result); end
  endtask

  task automatic test_back_to_back;
    int n;
    issue(OP_ADD, 1'b0, 8'h12, 8'h34);
    repeat (3) @(posedge clk);
    #1;
    // Start with different operands while RUN; must be ignored.
    op = OP_AND; binvert = 1'b1; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    checks++; if (n != W - 3)        begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", n, W - 3); end
    checks++; if (result !== 8'h46)  begin errors++; $display("FAIL ignore_result got=%h exp=46", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ignore_overflow got=%b exp=0", overflow); end
    // Start in the done cycle is accepted on the following edge.
    issue(OP_ADD, 1'b0, 8'h05, 8'h03);
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL b2b_done_low got=%b exp=0", done); end
    wait_done(n);
    checks++; if (n + 1 != W + 2)    begin errors++; $display("FAIL b2b_period got=%0d exp=%0d", n + 1, W + 2); end
    checks++; if (result !== 8'h08)  begin errors++; $display("FAIL b2b_result got=%h exp=08", result); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    issue(OP_ADD, 1'b0, 8'h0F, 8'h01);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (result !== 8'h00)  begin errors++; $display("FAIL abort_result got=%h exp=00", result); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0)     begin errors++; $display("FAIL abort_no_done got=%b exp=0", seen); end
  endtask

  task automatic test_zero;
    int n;
    issue(OP_ADD, 1'b1, 8'h10, 8'h10);
    wait_done(n);
    checks++; if (result !== 8'h00)  begin errors++; $display("FAIL zero_result got=%h exp=00", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL zero_overflow got=%b exp=0", overflow); end
`ifdef ALU_SERIAL_ZERO_EN
    checks++; if (zero !== 1'b1)     begin errors++; $display("FAIL zero_flag got=%b exp=1", zero); end
`endif
    issue(OP_ADD, 1'b0, 8'h01, 8'h01);
    wait_done(n);
    checks++; if (result !== 8'h02)  begin errors++; $display("FAIL nz_result got=%h exp=02", result); end
`ifdef ALU_SERIAL_ZERO_EN
    checks++; if (zero !== 1'b0)     begin errors++; $display("FAIL nz_flag got=%b exp=0", zero); end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_and_or();
    test_back_to_back();
    test_reset_mid();
    test_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
